fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding memory request feeding a small
// in-order queue of {instruction, pc} pairs toward decode, with redirect and halt.
module fetch_queue #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 2,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  dec_pc_plus,
    input  logic               dec_ready,
    output logic               full,
    output logic               empty,
    output logic               err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic [ADDR_W-1:0]  next_pc, fetch_base;
    logic               drop, halted, halted_next;
    logic               ack, push, pop, pending_next, issue;

    function automatic logic misaligned(input logic [ADDR_W-1:0] pc);
        return (pc % ADDR_W'(PC_INC)) != '0;
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign dec_valid   = !empty && !redirect;
    assign dec_instr   = q_instr[rd_ptr];
    assign dec_pc      = q_pc[rd_ptr];
    assign dec_pc_plus = dec_pc + ADDR_W'(PC_INC);

    // Everything below is judged on the occupancy left after this cycle's
    // push/pop/flush, so a freed slot can be refilled with no bubble.
    always_comb begin
        ack          = imem_ack && imem_req;
        push         = ack && !drop && !redirect;
        pop          = dec_valid && dec_ready;
        halted_next  = halted || halt;
        pending_next = imem_req && !ack;
        fetch_base   = redirect ? redirect_pc : next_pc;
        count_next   = count;
        if (redirect)
            count_next = '0;
        else
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        issue = (count_next < CNT_W'(DEPTH)) && !pending_next && !halted_next;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= imem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            next_pc   <= ADDR_W'(RESET_PC);
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            drop      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            halted <= halted_next;
            count  <= count_next;
            if ((imem_ack && !imem_req) || (redirect && misaligned(redirect_pc)))
                err <= 1'b1;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // An in-flight request cannot be cancelled, so its return is marked stale.
            if (redirect && pending_next)
                drop <= 1'b1;
            else if (ack)
                drop <= 1'b0;
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_base;
                next_pc   <= fetch_base + ADDR_W'(PC_INC);
            end else begin
                if (ack) imem_req <= 1'b0;
                next_pc <= fetch_base;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: a small memory responder plus a scoreboard of
// expected {pc, instr} pairs checked at every decode handshake.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        dec_valid;
    logic [15:0] dec_instr, dec_pc, dec_pc_plus;
    logic        dec_ready = 1'b0;
    logic        full, empty, err;

    logic        ack_mode = 1'b0;
    logic        force_ack = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          ack_count = 0;
    logic [15:0] expq [$];

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    assign imem_ack   = force_ack | (ack_mode & imem_req);
    assign imem_rdata = mem_data(imem_addr);

    fetch_queue dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus(dec_pc_plus),
        .dec_ready(dec_ready), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted decode transfer must match the next expected pc.
    always @(negedge clk) begin
        logic [15:0] ep;
        if (!rst && imem_ack) ack_count++;
        if (!rst && dec_valid && dec_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got pc=%h want no transfer", dec_pc);
            end else begin
                ep = expq.pop_front();
                if (dec_pc !== ep || dec_instr !== mem_data(ep) || dec_pc_plus !== ep + 16'd2) begin
                    errors++;
                    $display("FAIL pop_data got pc=%h instr=%h plus=%h want pc=%h instr=%h plus=%h",
                             dec_pc, dec_instr, dec_pc_plus, ep, mem_data(ep), ep + 16'd2);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ack_mode = 1'b0; force_ack = 1'b0; redirect = 1'b0;
        halt = 1'b0; dec_ready = 1'b0; redirect_pc = '0;
        expq.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got %0d pending want 0", name, expq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0 || empty !== 1'b1 || full !== 1'b0 ||
            dec_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got req=%b addr=%h empty=%b full=%b dv=%b err=%b want 0 0000 1 0 0 0",
                     imem_req, imem_addr, empty, full, dec_valid, err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_first_cycle got req=%b want 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_second_cycle got req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        ack_mode = 1'b1; dec_ready = 1'b1;
        expq.push_back(16'h0000); expq.push_back(16'h0002);
        expq.push_back(16'h0004); expq.push_back(16'h0006);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 16'(2 * i)) begin
                errors++;
                $display("FAIL stream_head%0d got dv=%b pc=%h want 1 %h", i, dec_valid, dec_pc, 16'(2 * i));
            end
            if (i < 2) tick();
        end
        checks++;
        if (dec_pc_plus !== 16'h0006) begin
            errors++; $display("FAIL stream_pc_plus got %h want 0006", dec_pc_plus);
        end
        halt = 1'b1;
        tick(4);
        check_drained("stream");
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL stream_halted got req=%b want 0", imem_req);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ack_mode = 1'b1;
        ack_count = 0;
        for (int i = 0; i < 5; i++) expq.push_back(16'(2 * i));
        tick(8);
        checks++;
        if (ack_count !== 4 || full !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got acks=%0d full=%b req=%b want 4 1 0", ack_count, full, imem_req);
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            errors++; $display("FAIL bp_refill got req=%b addr=%h want 1 0008", imem_req, imem_addr);
        end
        tick(4);
        checks++;
        if (ack_count !== 5 || imem_req !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL bp_one_refill got acks=%0d req=%b full=%b want 5 0 1", ack_count, imem_req, full);
        end
        halt = 1'b1; dec_ready = 1'b1;
        tick(6);
        check_drained("bp");
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        ack_mode = 1'b1; dec_ready = 1'b1;
        expq.push_back(16'h0000);
        tick(3);
        ack_mode = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_setup got req=%b addr=%h dv=%b want 1 0004 0", imem_req, imem_addr, dec_valid);
        end
        tick();
        redirect = 1'b0;
        checks++;
        if (empty !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL redir_hold got empty=%b req=%b addr=%h want 1 1 0004", empty, imem_req, imem_addr);
        end
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || empty !== 1'b1) begin
            errors++;
            $display("FAIL redir_drop got req=%b addr=%h empty=%b want 1 0100 1", imem_req, imem_addr, empty);
        end
        expq.push_back(16'h0100);
        halt = 1'b1; ack_mode = 1'b1;
        tick(4);
        check_drained("redir");
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        ack_mode = 1'b1;
        tick(4);
        checks++;
        if (full !== 1'b0 || empty !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL rap_setup got full=%b empty=%b req=%b addr=%h want 0 0 1 0006",
                     full, empty, imem_req, imem_addr);
        end
        redirect = 1'b1; redirect_pc = 16'h0040; dec_ready = 1'b1;
        tick();
        redirect = 1'b0;
        checks++;
        if (empty !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL rap_flush got empty=%b req=%b addr=%h want 1 1 0040", empty, imem_req, imem_addr);
        end
        expq.push_back(16'h0040);
        halt = 1'b1;
        tick(4);
        check_drained("rap");
    endtask

    task automatic test_halt_err();
        do_reset();
        dec_ready = 1'b1;
        tick();
        halt = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL halt_inflight got req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
        expq.push_back(16'h0000);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick(3);
        checks++;
        if (imem_req !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL halt_stop got req=%b err=%b want 0 0", imem_req, err);
        end
        check_drained("halt");
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick(3);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_spurious_ack got %b want 1", err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %b want 0", err);
        end
        redirect = 1'b1; redirect_pc = 16'h0003;
        tick();
        redirect = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_misaligned got %b want 1", err);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        ack_mode = 1'b1; dec_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        expq.push_back(16'hFFFE); expq.push_back(16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_first got req=%b addr=%h want 1 fffe", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL wrap_second got req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
        halt = 1'b1;
        tick(4);
        check_drained("wrap");
        do_reset();
        ack_mode = 1'b1;
        tick(4);
        rst = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0 || empty !== 1'b1 || full !== 1'b0 ||
            dec_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset got req=%b addr=%h empty=%b full=%b dv=%b err=%b want 0 0000 1 0 0 0",
                     imem_req, imem_addr, empty, full, dec_valid, err);
        end
        rst = 1'b0; ack_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_ack_pop();
        test_halt_err();
        test_wrap_and_reset();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
